cache_control: RTL and testbench
================================

// Module: cache_control
// PURPOSE
//  Control FSM for the 2-way set-associative L1 cache (8 sets, 3-bit index).
//  Sits directly upstream of the per-way data/tag/valid/dirty/LRU arrays and drives
//  their write enables. Consumes hit/dirty/LRU status that the datapath derives from
//  the array outputs. Runs the CPU-side and physical-memory handshakes.
//  Keeps saturating hit and miss counters for performance measurement.
// PARAMETERS
//  COUNT_WIDTH  16  width of hit_count and miss_count
// PORTS
//  clk         in   1   clock; all state changes on posedge
//  rst_n       in   1   asynchronous, active-low reset
//  mem_read    in   1   CPU read request; held until mem_resp
//  mem_write   in   1   CPU write request; held until mem_resp
//  hit0/hit1   in   1   way0/way1 valid & tag match (combinational from arrays)
//  dirty0/1    in   1   dirty bit of way0/way1 at current index
//  lru         in   1   LRU array output: way to evict
//  pmem_resp   in   1   physical memory done (one-cycle pulse)
//  mem_resp    out  1   CPU request complete
//  pmem_read   out  1   line fill request
//  pmem_write  out  1   line writeback request
//  load_way0/1 out  1   write enable for data/tag/valid/dirty arrays of that way
//  data_sel    out  1   array data source: 0 = CPU merge, 1 = pmem line
//  dirty_in    out  1   value written to the dirty array with load_way*
//  load_lru    out  1   LRU array write enable
//  lru_in      out  1   value written to the LRU array
//  wb_addr_sel out  1   pmem address source: 1 = victim tag+index, 0 = CPU address
//  hit_count   out  CW  number of requests served without a miss
//  miss_count  out  CW  number of misses taken
// BEHAVIOUR
//  - States: IDLE, WRITEBACK, ALLOCATE. Registers: state, victim_q, refill_q, counters.
//  - All control outputs are combinational from the state and inputs. They are 0
//    unless asserted below. Reset: state=IDLE, victim_q=0, refill_q=0, counters=0,
//    so every output is 0 while rst_n=0. The reset takes effect asynchronously,
//    including mid-WRITEBACK or mid-ALLOCATE.
//  - req = mem_read | mem_write. If both are set, the request is treated as a write.
//  - hit = hit0 | hit1; hit_way = hit0 ? 0 : 1. If both hits are set, way0 wins.
//  - IDLE, req & hit (zero-wait-state):
//      mem_resp=1 and load_lru=1 in the same cycle; lru_in = ~hit_way.
//      On a write, also load_way[hit_way]=1, data_sel=0, dirty_in=1.
//      hit_count increments unless refill_q=1.
//  - IDLE, req & !hit:
//      victim_q <= lru; miss_count increments.
//      Next state is WRITEBACK if the selected dirty bit (dirty1 if lru else dirty0)
//      is set, otherwise ALLOCATE.
//  - WRITEBACK: pmem_write=1, wb_addr_sel=1. Stays until pmem_resp, then goes to
//    ALLOCATE.
//  - ALLOCATE: pmem_read=1, wb_addr_sel=0. On pmem_resp: load_way[victim_q]=1,
//    data_sel=1, dirty_in=0, refill_q <= 1, next state IDLE.
//    The following IDLE cycle sees the hit and serves the request.
//  - refill_q clears after exactly one IDLE cycle.
//  - The refill-then-hit serve is not counted as a hit. Misses are counted exactly
//    once per miss.
//  - If req drops during WRITEBACK or ALLOCATE, the sequence still completes. No
//    mem_resp is issued afterwards if req is low in IDLE.
//  - pmem_read and pmem_write are never asserted together.
//  - Neither pmem request is asserted in IDLE.
//  - Counters saturate at all-ones and do not wrap.
//  - Miss-to-serve latency: 1 cycle to leave IDLE, plus pmem latency per phase,
//    plus 1 IDLE serve cycle.
// TESTING
//  - Clean read miss: mem_read=1, no hits, lru=1, dirty1=0, pmem_resp after 5 cycles
//    -> pmem_read=1 for those cycles; on resp load_way1=1, data_sel=1, dirty_in=0.
//    Next cycle with hit1=1: mem_resp=1, load_lru=1, lru_in=0; miss=1, hit=0.
//  - Dirty write miss: mem_write=1, lru=0, dirty0=1 -> pmem_write=1 with
//    wb_addr_sel=1 until resp (3 cycles), then pmem_read. After the fill, the hit0
//    cycle gives load_way0=1, data_sel=0, dirty_in=1, mem_resp=1.
//  - Back-to-back: 4 consecutive read hits on way0 -> mem_resp=1 each cycle,
//    lru_in=1, hit_count=4, no pmem activity.
//  - Both hit0=hit1=1 on a write -> load_way0=1 only, lru_in=1.
//  - Saturation: COUNT_WIDTH=4, 20 hits -> hit_count=15.
//  - Reset mid-WRITEBACK: drop rst_n -> pmem_write=0 immediately, state IDLE,
//    counters 0. After release, an idle bus gives all outputs 0.

Source files
------------

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache: drives array write enables,
// runs the CPU and physical-memory handshakes, and keeps saturating hit/miss counters.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | serve hits in zero wait states; on a miss pick the victim
//   WRITEBACK | write the dirty victim line back to physical memory
//   ALLOCATE  | fill the victim way from physical memory, then return to IDLE
module cache_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   hit0,
    input  logic                   hit1,
    input  logic                   dirty0,
    input  logic                   dirty1,
    input  logic                   lru,
    input  logic                   pmem_resp,
    output logic                   mem_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic                   load_way0,
    output logic                   load_way1,
    output logic                   data_sel,
    output logic                   dirty_in,
    output logic                   load_lru,
    output logic                   lru_in,
    output logic                   wb_addr_sel,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   victim_q;
    logic   refill_q;

    logic req;
    logic hit;
    logic hit_way;
    logic victim_dirty;
    logic hit_inc;
    logic miss_inc;
    logic refill_done;

    // A simultaneous read and write is handled as a write, so only mem_write matters below.
    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = ~hit0;
    assign victim_dirty = lru ? dirty1 : dirty0;

    always_comb begin
        state_next  = state;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        load_way0   = 1'b0;
        load_way1   = 1'b0;
        data_sel    = 1'b0;
        dirty_in    = 1'b0;
        load_lru    = 1'b0;
        lru_in      = 1'b0;
        wb_addr_sel = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        refill_done = 1'b0;

        case (state)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = ~hit_way;
                    hit_inc  = ~refill_q;
                    if (mem_write) begin
                        load_way0 = ~hit_way;
                        load_way1 = hit_way;
                        data_sel  = 1'b0;
                        dirty_in  = 1'b1;
                    end
                end else if (req) begin
                    miss_inc   = 1'b1;
                    state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                wb_addr_sel = 1'b1;
                if (pmem_resp) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_way0   = ~victim_q;
                    load_way1   = victim_q;
                    data_sel    = 1'b1;
                    dirty_in    = 1'b0;
                    refill_done = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_q <= 1'b0;
        end else if (miss_inc) begin
            victim_q <= lru;
        end
    end

    // refill_q marks the single IDLE cycle after a fill so that serve is not counted as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_q <= 1'b0;
        end else if (refill_done) begin
            refill_q <= 1'b1;
        end else if (state == IDLE) begin
            refill_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (hit_inc && (hit_count != {COUNT_WIDTH{1'b1}})) begin
            hit_count <= hit_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= '0;
        end else if (miss_inc && (miss_count != {COUNT_WIDTH{1'b1}})) begin
            miss_count <= miss_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: a 16-bit-counter instance for behaviour and a
// 4-bit-counter instance sharing the same stimulus for counter saturation.
module tb_cache_control;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp;

    logic        mem_resp, pmem_read, pmem_write, load_way0, load_way1;
    logic        data_sel, dirty_in, load_lru, lru_in, wb_addr_sel;
    logic [15:0] hit_count, miss_count;

    logic        s_mem_resp, s_pmem_read, s_pmem_write, s_load_way0, s_load_way1;
    logic        s_data_sel, s_dirty_in, s_load_lru, s_lru_in, s_wb_addr_sel;
    logic [3:0]  s_hit_count, s_miss_count;

    logic [9:0]  outs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign outs = {mem_resp, pmem_read, pmem_write, load_way0, load_way1,
                   data_sel, dirty_in, load_lru, lru_in, wb_addr_sel};

    cache_control #(.COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
        .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .load_way0(load_way0), .load_way1(load_way1), .data_sel(data_sel),
        .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in),
        .wb_addr_sel(wb_addr_sel), .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
        .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .load_way0(s_load_way0), .load_way1(s_load_way1), .data_sel(s_data_sel),
        .dirty_in(s_dirty_in), .load_lru(s_load_lru), .lru_in(s_lru_in),
        .wb_addr_sel(s_wb_addr_sel), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; hit0 = 0; hit1 = 0;
        dirty0 = 0; dirty1 = 0; lru = 0; pmem_resp = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #3;
        check("reset_outs", outs, 10'h000);
        check("reset_hits", hit_count, 0);
        check("reset_miss", miss_count, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // four back-to-back read hits on way0
        mem_read = 1; hit0 = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("b2b_resp", mem_resp, 1);
            check("b2b_load_lru", load_lru, 1);
            check("b2b_lru_in", lru_in, 1);
            check("b2b_no_pmem", {pmem_read, pmem_write}, 2'b00);
            check("b2b_no_load", {load_way0, load_way1}, 2'b00);
            tick();
        end
        clear_inputs();
        #1;
        check("b2b_hits", hit_count, 4);
        check("b2b_miss", miss_count, 0);

        // clean read miss, victim way1, pmem answers on the 5th ALLOCATE cycle
        mem_read = 1; lru = 1; dirty1 = 0;
        #1;
        check("crm_idle_resp", mem_resp, 0);
        check("crm_idle_pmem", {pmem_read, pmem_write}, 2'b00);
        tick();
        check("crm_miss", miss_count, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("crm_pread", {pmem_read, pmem_write, load_way1}, 3'b100);
            tick();
        end
        pmem_resp = 1;
        #1;
        check("crm_fill", {pmem_read, load_way0, load_way1, data_sel, dirty_in}, 5'b10110);
        tick();
        pmem_resp = 0; hit1 = 1;
        #1;
        check("crm_serve", {mem_resp, load_lru, lru_in, load_way1}, 4'b1100);
        check("crm_serve_pmem", {pmem_read, pmem_write}, 2'b00);
        tick();
        clear_inputs();
        #1;
        check("crm_hits", hit_count, 4);
        check("crm_miss2", miss_count, 1);

        // dirty write miss on way0; lru changes afterwards but victim stays latched
        mem_write = 1; lru = 0; dirty0 = 1;
        #1;
        check("dwm_idle_pmem", {pmem_read, pmem_write}, 2'b00);
        tick();
        lru = 1;
        check("dwm_miss", miss_count, 2);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("dwm_wb", {pmem_write, wb_addr_sel, pmem_read}, 3'b110);
            tick();
        end
        pmem_resp = 1;
        #1;
        check("dwm_wb_resp", {pmem_write, wb_addr_sel, load_way0, load_way1}, 4'b1100);
        tick();
        pmem_resp = 0;
        #1;
        check("dwm_alloc", {pmem_read, pmem_write, wb_addr_sel}, 3'b100);
        tick();
        pmem_resp = 1;
        #1;
        check("dwm_fill", {load_way0, load_way1, data_sel, dirty_in}, 4'b1010);
        tick();
        pmem_resp = 0; hit0 = 1;
        #1;
        check("dwm_serve", {mem_resp, load_way0, load_way1, data_sel, dirty_in, lru_in}, 6'b110011);
        tick();
        clear_inputs();
        #1;
        check("dwm_hits", hit_count, 4);
        check("dwm_miss2", miss_count, 2);

        // ordinary hit right after a refill serve is counted
        mem_read = 1; hit1 = 1;
        #1;
        check("post_hit_resp", {mem_resp, lru_in}, 2'b10);
        tick();
        clear_inputs();
        #1;
        check("post_hit_count", hit_count, 5);

        // read+write with both ways hitting: write to way0 only
        mem_read = 1; mem_write = 1; hit0 = 1; hit1 = 1;
        #1;
        check("both_hit", {mem_resp, load_way0, load_way1, dirty_in, lru_in}, 5'b11011);
        tick();
        clear_inputs();
        #1;
        check("both_hit_count", hit_count, 6);

        // request dropped during ALLOCATE: fill completes, no mem_resp afterwards
        mem_read = 1; lru = 0; dirty0 = 0;
        tick();
        mem_read = 0;
        #1;
        check("drop_alloc", pmem_read, 1);
        tick();
        pmem_resp = 1;
        #1;
        check("drop_fill", {load_way0, load_way1, data_sel}, 3'b101);
        tick();
        pmem_resp = 0; hit0 = 1;
        #1;
        check("drop_no_resp", outs, 10'h000);
        tick();
        clear_inputs();
        #1;
        check("drop_counts", {hit_count, miss_count}, {16'd6, 16'd3});

        // reset asserted in the middle of WRITEBACK
        mem_write = 1; lru = 1; dirty1 = 1;
        tick();
        #1;
        check("rst_wb_active", pmem_write, 1);
        rst_n = 0;
        #1;
        check("rst_wb_pwrite", {pmem_write, wb_addr_sel}, 2'b00);
        check("rst_counts", {hit_count, miss_count}, 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
        check("rst_idle_outs", outs, 10'h000);
        tick();
        check("rst_idle_outs2", outs, 10'h000);
        check("rst_sat_counts", {s_hit_count, s_miss_count}, 8'h00);

        // 20 hits: 16-bit counter reaches 20, 4-bit counter sticks at 15
        mem_read = 1; hit0 = 1;
        for (int i = 0; i < 20; i++) tick();
        clear_inputs();
        #1;
        check("sat_hits16", hit_count, 20);
        check("sat_hits4", s_hit_count, 15);
        check("sat_miss4", s_miss_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
